bq_gpio_out: RTL and testbench



---
 rtl/bq_pkg.sv | 15 +
 rtl/bq_sync_fifo.sv | 47 ++++
 rtl/bq_gpio_out.sv | 114 +++++++++++
 tb/tb_bq_gpio_out.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bq_pkg.sv
// Shared types and constants for the biquad datapath.
// The output stage and the biquad core both import this package.
package bq_pkg;

  localparam int BYTE_W     = 8;
  localparam int GPIO_LSB   = 0;
  localparam int DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO
  } state_t;

endpackage

// File: rtl/bq_sync_fifo.sv
// Single-clock sample FIFO with occupancy count.
// Pointers wrap modulo DEPTH; DEPTH must be a power of two.
module bq_sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/bq_gpio_out.sv
// Biquad output stage: buffers samples and serialises them onto
// mprj_io[7:0] as high byte then low byte, each held hold_cycles.
module bq_gpio_out
  import bq_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 8,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic [7:0]        io_out,
  output logic [7:0]        io_oeb,
  output logic              io_strobe,
  output logic [LW-1:0]     fifo_level,
  output logic              busy
);

  state_t            state;
  logic [DW-1:0]     sample_r;
  logic [HOLD_W-1:0] cnt;
  logic [HOLD_W-1:0] load;
  logic              rdy_r;
  logic              fresh;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DW-1:0]     rdata;

  bq_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst_n (resetb),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .rdata (rdata),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  // rdy_r keeps s_ready low until the first edge after reset release
  assign s_ready = rdy_r & ~full;
  assign push    = s_valid & s_ready;
  assign load    = (hold_cycles == '0) ? '0
                 : hold_cycles - HOLD_W'(1);
  assign pop     = ~empty & ((state == IDLE) |
                   ((state == LO) & (cnt == '0)));
  assign busy    = (state != IDLE) | ~empty;
  assign io_oeb  = '0;

  // io_out trails the state by one edge; fresh marks a byte's first cycle
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      sample_r  <= '0;
      cnt       <= '0;
      rdy_r     <= 1'b0;
      fresh     <= 1'b0;
      io_out    <= '0;
      io_strobe <= 1'b0;
    end else begin
      rdy_r     <= 1'b1;
      fresh     <= 1'b0;
      io_strobe <= fresh;
      unique case (state)
        IDLE: begin
          if (pop) begin
            sample_r <= rdata;
            cnt      <= load;
            fresh    <= 1'b1;
            state    <= HI;
          end
        end
        HI: begin
          io_out <= sample_r[DW-1 -: BYTE_W];
          if (cnt == '0) begin
            cnt   <= load;
            fresh <= 1'b1;
            state <= LO;
          end else begin
            cnt <= cnt - HOLD_W'(1);
          end
        end
        LO: begin
          io_out <= sample_r[BYTE_W-1:0];
          if (cnt == '0) begin
            if (pop) begin
              sample_r <= rdata;
              cnt      <= load;
              fresh    <= 1'b1;
              state    <= HI;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bq_gpio_out.sv
// Self-checking bench for bq_gpio_out: vector table, directed
// corner sequences and a randomized run against a byte-stream model.
module tb_bq_gpio_out;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic [7:0]  hold_cycles = '0;
  logic [7:0]  io_out;
  logic [7:0]  io_oeb;
  logic        io_strobe;
  logic [2:0]  fifo_level;
  logic        busy;

  int total = 0;
  int pass = 0;
  int cyc = 0;

  logic [7:0]  mb[$];
  int          mc[$];
  logic [15:0] exq[$];

  typedef struct {
    logic [7:0]  hold;
    logic [15:0] data;
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          dur;
  } vec_t;

  vec_t tv[5];

  bq_gpio_out dut (
    .clock       (clock),
    .resetb      (resetb),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .hold_cycles (hold_cycles),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .io_strobe   (io_strobe),
    .fifo_level  (fifo_level),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (io_strobe) begin
      mb.push_back(io_out);
      mc.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    int w = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && w < 1000) begin
      step;
      w++;
    end
    if (w >= 1000) chk("push_timeout", 0, 1);
    step;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int w = 0;
    while (busy && w < 2000) begin
      step;
      w++;
    end
    if (w >= 2000) chk("idle_timeout", 0, 1);
    step;
    step;
  endtask

  task automatic clr;
    mb.delete();
    mc.delete();
    exq.delete();
  endtask

  task automatic cmp_stream(input string nm);
    logic [7:0] b;
    chk({nm, "_len"}, mb.size(), 2 * exq.size());
    for (int i = 0; i < mb.size() && i < 2 * exq.size(); i++) begin
      b = (i % 2 == 0) ? exq[i/2][15:8] : exq[i/2][7:0];
      chk({nm, "_byte"}, mb[i], b);
    end
  endtask

  task automatic run_vec(input vec_t v);
    hold_cycles = v.hold;
    push(v.data);
    chk("vec_level_push", fifo_level, 1);
    chk("vec_nostrobe_n", io_strobe, 0);
    step;
    chk("vec_level_pop", fifo_level, 0);
    chk("vec_nostrobe_n1", io_strobe, 0);
    step;
    chk("vec_hi", io_out, v.hi);
    chk("vec_hi_strobe", io_strobe, 1);
    for (int i = 1; i < v.dur; i++) begin
      step;
      chk("vec_hi_hold", {io_strobe, io_out}, {1'b0, v.hi});
    end
    step;
    chk("vec_lo", io_out, v.lo);
    chk("vec_lo_strobe", io_strobe, 1);
    for (int i = 1; i < v.dur; i++) begin
      step;
      chk("vec_lo_hold", {io_strobe, io_out}, {1'b0, v.lo});
    end
    step;
    chk("vec_idle_out", {io_strobe, io_out}, {1'b0, v.lo});
    chk("vec_idle_busy", busy, 0);
  endtask

  task automatic rand_run(input int n, input logic [7:0] h);
    int   sent = 0;
    int   lim = 0;
    int   dur;
    logic rdy;
    hold_cycles = h;
    dur = (h == 0) ? 1 : int'(h);
    clr();
    while (sent < n && lim < 20000) begin
      if (!s_valid && ($urandom % 3 != 0)) begin
        s_valid = 1'b1;
        s_data  = 16'($urandom);
      end
      rdy = s_ready;
      step;
      lim++;
      if (s_valid && rdy) begin
        exq.push_back(s_data);
        sent++;
        s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    if (sent < n) chk("rand_timeout", sent, n);
    wait_idle();
    cmp_stream("rand");
    for (int i = 0; i + 1 < mc.size(); i++) begin
      if (i % 2 == 0) chk("rand_hi_dur", mc[i+1] - mc[i], dur);
      else chk("rand_gap_min", (mc[i+1] - mc[i]) >= dur, 1);
    end
  endtask

  initial begin
    tv[0] = '{8'd3, 16'h1234, 8'h12, 8'h34, 3};
    tv[1] = '{8'd0, 16'hA55A, 8'hA5, 8'h5A, 1};
    tv[2] = '{8'd1, 16'hFFFF, 8'hFF, 8'hFF, 1};
    tv[3] = '{8'd2, 16'h8001, 8'h80, 8'h01, 2};
    tv[4] = '{8'd4, 16'h0000, 8'h00, 8'h00, 4};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_io_out", io_out, 8'h00);
    chk("rst_io_oeb", io_oeb, 8'h00);
    chk("rst_strobe", io_strobe, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    resetb = 1'b1;
    #1;
    chk("rel_s_ready_pre", s_ready, 0);
    step;
    chk("rel_s_ready_post", s_ready, 1);

    for (int i = 0; i < 5; i++) run_vec(tv[i]);

    // streaming, one byte per cycle
    clr();
    hold_cycles = 8'd0;
    for (int i = 1; i <= 10; i++) begin
      push(16'(i));
      exq.push_back(16'(i));
    end
    push(16'hFF00);
    exq.push_back(16'hFF00);
    wait_idle();
    cmp_stream("stream");
    if (mc.size() == 22) chk("stream_nogap", mc[21] - mc[0], 21);

    // full FIFO back-pressure
    clr();
    hold_cycles = 8'd10;
    for (int i = 0; i < 5; i++) begin
      push(16'hC100 + 16'(i));
      exq.push_back(16'hC100 + 16'(i));
    end
    chk("full_level", fifo_level, 4);
    chk("full_ready", s_ready, 0);
    s_valid = 1'b1;
    s_data  = 16'hC105;
    for (int i = 0; i < 6; i++) begin
      step;
      chk("full_hold", {s_ready, fifo_level}, {1'b0, 3'd4});
    end
    push(16'hC105);
    exq.push_back(16'hC105);
    chk("full_refill", fifo_level, 4);
    wait_idle();
    cmp_stream("full");

    // hold change mid-byte
    hold_cycles = 8'd5;
    push(16'h5AC3);
    step;
    step;
    chk("hc_hi", {io_strobe, io_out}, {1'b1, 8'h5A});
    hold_cycles = 8'd2;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("hc_hi_hold", {io_strobe, io_out}, {1'b0, 8'h5A});
    end
    step;
    chk("hc_lo", {io_strobe, io_out}, {1'b1, 8'hC3});
    step;
    chk("hc_lo2", {io_strobe, io_out}, {1'b0, 8'hC3});
    chk("hc_lo2_busy", busy, 0);

    // reset during LO with three samples queued
    hold_cycles = 8'd3;
    for (int i = 0; i < 4; i++) push(16'h7700 + 16'(i));
    step;
    step;
    chk("mid_level", fifo_level, 3);
    chk("mid_lo", io_out, 8'h00);
    resetb = 1'b0;
    #1;
    chk("mid_rst_out", io_out, 8'h00);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", s_ready, 0);
    clr();
    step;
    step;
    resetb = 1'b1;
    step;
    chk("mid_rel_ready", s_ready, 1);
    push(16'hABCD);
    exq.push_back(16'hABCD);
    wait_idle();
    cmp_stream("after_rst");

    rand_run(30, 8'($urandom_range(0, 3)));
    rand_run(30, 8'd2);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
